// File: rtl/spi_minion_pkg.sv
// Shared types and constants for the SPI minion front-end.
package spi_minion_pkg;

  // Transaction-level state of the minion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_minion_state_t;

  // Metastability flops per pad pin, before the edge-detect flop.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_minion_sync.sv
// Pad-pin synchronizer: SYNC_STAGES flops into clk, plus one extra flop
// so that rising/falling edges of the synchronized level can be detected.
module spi_minion_sync
  import spi_minion_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // chain_q[0] is the first metastability flop, chain_q[SYNC_STAGES] the edge-detect flop.
  logic [SYNC_STAGES:0] chain_q;
  logic [SYNC_STAGES:0] chain_d;

  // Shift the raw pin down the chain every clock.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-1:0], din};
  end

  // Chain register, reset to the pin's idle level so no false edge appears after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain_q <= {(SYNC_STAGES+1){RESET_VAL}};
    else        chain_q <= chain_d;
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  =  chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
  assign fall  = ~chain_q[SYNC_STAGES-1] &  chain_q[SYNC_STAGES];

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI minion front-end (mode 0, MSB first, fixed packet length).
// Deserializes MOSI into a val/rdy recv stream, serializes a val/rdy send
// stream onto MISO, and reports parity of the last delivered packet.
module spi_minion_frontend
  import spi_minion_pkg::*;
#(
  parameter int BIT_WIDTH = 34
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  output logic [BIT_WIDTH-1:0] recv_msg,
  output logic                 recv_val,
  input  logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] send_msg,
  input  logic                 send_val,
  output logic                 send_rdy,
  output logic                 parity,
  output logic                 overflow
);

  localparam int CW = $clog2(BIT_WIDTH + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(BIT_WIDTH);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // Edge outputs that this block has no use for.
  logic unused_edges;
  assign unused_edges = cs_rise ^ sclk_lvl ^ mosi_rise ^ mosi_fall;

  spi_minion_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_minion_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_minion_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_minion_state_t    state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BIT_WIDTH-1:0] shift_in_q, shift_in_d;
  logic [BIT_WIDTH-1:0] shift_out_q, shift_out_d;
  logic [BIT_WIDTH-1:0] recv_msg_q, recv_msg_d;
  logic                 recv_val_q, recv_val_d;
  logic                 parity_q, parity_d;
  logic                 overflow_q, overflow_d;

  // Next-state, datapath and combinational outputs (miso, send_rdy).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    recv_msg_d  = recv_msg_q;
    recv_val_d  = recv_val_q & ~recv_rdy;
    parity_d    = parity_q;
    overflow_d  = 1'b0;
    send_rdy    = 1'b0;
    miso        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          send_rdy    = 1'b1;
          shift_out_d = send_val ? send_msg : '0;
          count_d     = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        miso = shift_out_q[BIT_WIDTH-1];
        if (count_q == COUNT_MAX) begin
          state_d = DONE;
          // A handshake in this same cycle frees the slot for the new packet.
          if (!recv_val_q || recv_rdy) begin
            recv_msg_d = shift_in_q;
            recv_val_d = 1'b1;
            parity_d   = ^shift_in_q;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (cs_lvl) begin
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[BIT_WIDTH-2:0], mosi_lvl};
            count_d    = count_q + 1'b1;
          end
          if (sclk_fall) begin
            shift_out_d = shift_out_q << 1;
          end
        end
      end
      DONE: begin
        if (cs_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drives every output low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      recv_msg_q  <= '0;
      recv_val_q  <= 1'b0;
      parity_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      recv_msg_q  <= recv_msg_d;
      recv_val_q  <= recv_val_d;
      parity_q    <= parity_d;
      overflow_q  <= overflow_d;
    end
  end

  assign recv_msg = recv_msg_q;
  assign recv_val = recv_val_q;
  assign parity   = parity_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Bench for spi_minion_frontend: an SPI master (sclk period 16 clk) drives
// packets; expected recv packets are queued at stimulus time and matched
// against what a monitor captures on recv handshakes.
module tb_spi_minion_frontend;
  localparam int BW = 34;
  typedef logic [BW:0] pkt_t;  // {parity, msg}

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, sclk, mosi, miso;
  logic [BW-1:0] recv_msg;
  logic          recv_val, recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val, send_rdy;
  logic          parity, overflow;

  pkt_t exp_q[$];
  pkt_t act_q[$];
  int   ovf_cnt = 0;
  int   rdy_cnt = 0;
  int   checks  = 0;
  int   passed  = 0;

  always #5 clk = ~clk;

  spi_minion_frontend #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .parity(parity), .overflow(overflow)
  );

  // Monitor: capture recv handshakes and count pulses, sampled away from posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (recv_val && recv_rdy) act_q.push_back({parity, recv_msg});
      if (overflow) ovf_cnt++;
      if (send_rdy) rdy_cnt++;
    end
  end

  // SPI master transaction. nbits < BW aborts by raising cs; reset_at >= 0
  // pulls reset low two clocks after that bit's sclk rise and returns at once.
  task automatic spi_xfer(input logic [BW-1:0] mo, input int nbits, input int reset_at,
                          output logic [BW-1:0] mi);
    mi = '0;
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[BW-1-i];
      repeat (8) @(negedge clk);
      mi[BW-1-i] = miso;
      sclk = 1'b1;
      if (i == reset_at) begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0; recv_rdy = 1'b0;
    send_msg = '0; send_val = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, recv_msg, recv_val, send_rdy, parity, overflow} !== '0)
      $display("FAIL reset_outputs: got %h expected 0",
               {miso, recv_msg, recv_val, send_rdy, parity, overflow});
    else passed++;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({miso, recv_val, send_rdy, overflow} !== 4'b0)
      $display("FAIL post_reset_idle: got %b expected 0000", {miso, recv_val, send_rdy, overflow});
    else passed++;
  endtask

  task automatic test_recv_basic();
    logic [BW-1:0] w, mi;
    pkt_t e, a;
    w = 34'h1_2345_6789;
    recv_rdy = 1'b1; send_val = 1'b0;
    exp_q.push_back({^w, w});
    spi_xfer(w, BW, -1, mi);
    checks++;
    if (act_q.size() != 1) $display("FAIL basic_pkt_count: got %0d expected 1", act_q.size());
    else passed++;
    if (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) $display("FAIL basic_pkt: got %h expected %h", a, e);
      else passed++;
    end
    checks++;
    if (recv_val !== 1'b0) $display("FAIL basic_val_clear: got %b expected 0", recv_val);
    else passed++;
  endtask

  task automatic test_send();
    logic [BW-1:0] w, mi, s;
    pkt_t e, a;
    int r0;
    w = 34'h0_1234_ABCD; s = 34'h3_FFFF_0000;
    send_msg = s; send_val = 1'b1; r0 = rdy_cnt;
    exp_q.push_back({^w, w});
    spi_xfer(w, BW, -1, mi);
    send_val = 1'b0;
    checks++;
    if (rdy_cnt - r0 != 1) $display("FAIL send_rdy_pulse: got %0d cycles expected 1", rdy_cnt - r0);
    else passed++;
    checks++;
    if (mi !== s) $display("FAIL send_miso: got %h expected %h", mi, s);
    else passed++;
    checks++;
    if (act_q.size() == 0) $display("FAIL send_recv_pkt: got none expected %h", exp_q[0]);
    else begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      if (a !== e) $display("FAIL send_recv_pkt: got %h expected %h", a, e);
      else passed++;
    end
  endtask

  task automatic test_send_idle();
    logic [BW-1:0] w, mi;
    pkt_t e, a;
    int r0;
    w = 34'h0_0000_0003;
    send_msg = 34'h2_5A5A_5A5A; send_val = 1'b0; r0 = rdy_cnt;
    exp_q.push_back({^w, w});
    spi_xfer(w, BW, -1, mi);
    checks++;
    if (rdy_cnt - r0 != 1) $display("FAIL idle_rdy_pulse: got %0d expected 1", rdy_cnt - r0);
    else passed++;
    checks++;
    if (mi !== '0) $display("FAIL idle_miso: got %h expected 0", mi);
    else passed++;
    checks++;
    if (act_q.size() == 0) $display("FAIL idle_recv_pkt: got none expected %h", exp_q[0]);
    else begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      if (a !== e) $display("FAIL idle_recv_pkt: got %h expected %h", a, e);
      else passed++;
    end
  endtask

  task automatic test_abort();
    logic [BW-1:0] w, mi;
    pkt_t e, a;
    int o0;
    w = 34'h2_AAAA_5555; o0 = ovf_cnt;
    spi_xfer(34'h3_C3C3_C3C3, 10, -1, mi);
    checks++;
    if (act_q.size() != 0 || ovf_cnt != o0)
      $display("FAIL abort_no_output: got %0d pkts %0d ovf expected 0 0", act_q.size(), ovf_cnt - o0);
    else passed++;
    exp_q.push_back({^w, w});
    spi_xfer(w, BW, -1, mi);
    checks++;
    if (act_q.size() != 1) $display("FAIL abort_next_count: got %0d expected 1", act_q.size());
    else passed++;
    if (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) $display("FAIL abort_next_pkt: got %h expected %h", a, e);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] mi;
    pkt_t e, a;
    int o0;
    recv_rdy = 1'b0; o0 = ovf_cnt;
    exp_q.push_back({1'b1, 34'h0_0000_0001});
    spi_xfer(34'h0_0000_0001, BW, -1, mi);
    checks++;
    if (ovf_cnt != o0) $display("FAIL ovf_first: got %0d pulses expected 0", ovf_cnt - o0);
    else passed++;
    spi_xfer(34'h0_0000_0002, BW, -1, mi);
    checks++;
    if (ovf_cnt - o0 != 1) $display("FAIL ovf_second: got %0d pulses expected 1", ovf_cnt - o0);
    else passed++;
    checks++;
    if ({recv_val, parity, recv_msg} !== {1'b1, 1'b1, 34'h0_0000_0001})
      $display("FAIL ovf_held: got %b %b %h expected 1 1 000000001", recv_val, parity, recv_msg);
    else passed++;
    recv_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (recv_val !== 1'b0) $display("FAIL ovf_drain_val: got %b expected 0", recv_val);
    else passed++;
    checks++;
    if (act_q.size() != 1) $display("FAIL ovf_drain_count: got %0d expected 1", act_q.size());
    else begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      if (a !== e) $display("FAIL ovf_drain_pkt: got %h expected %h", a, e);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic [BW-1:0] w, mi;
    pkt_t e, a;
    w = 34'h1_0000_0000;
    recv_rdy = 1'b1;
    send_msg = 34'h3_FFFF_FFFF; send_val = 1'b1;
    // Hold a packet so recv_val/recv_msg/parity are nonzero when reset hits.
    recv_rdy = 1'b0;
    spi_xfer(34'h0_0000_0007, BW, -1, mi);
    spi_xfer(34'h0_0000_0000, BW, 17, mi);
    checks++;
    if (miso !== 1'b1 && reset !== 1'b0)
      $display("FAIL mid_reset_setup: got %b expected 1", miso);
    else passed++;
    #1;
    checks++;
    if ({miso, recv_msg, recv_val, send_rdy, parity, overflow} !== '0)
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {miso, recv_msg, recv_val, send_rdy, parity, overflow});
    else passed++;
    send_val = 1'b0; recv_rdy = 1'b1;
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    act_q.delete();
    exp_q.push_back({^w, w});
    spi_xfer(w, BW, -1, mi);
    checks++;
    if (act_q.size() != 1) $display("FAIL mid_reset_count: got %0d expected 1", act_q.size());
    else begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      if (a !== e) $display("FAIL mid_reset_pkt: got %h expected %h", a, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_recv_basic();
    test_send();
    test_send_idle();
    test_abort();
    test_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
